// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative multiply/divide unit for the EX stage. Runs
//               mult/multu/div/divu over WIDTH cycles, one shift-add or
//               restoring shift-subtract step per cycle, and owns HI/LO.
//               Raises a stall while busy and a later instruction needs
//               the unit or HI/LO.
//               Optional feature macro: MULDIV_SIGNED_EN (signed mult/div
//               for op 00/10); when undefined all ops run unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_rd,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    // Multiply: {partial high, multiplier shifting out}.
    // Divide:   {remainder, quotient shifting in as dividend shifts out}.
    // Divide-by-zero: {raw rs_val, all ones} ready to copy into HI/LO.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic               w_div_zero;

    logic [WIDTH:0]     w_mul_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign busy  = (r_state != ST_IDLE);
    assign stall = busy & (start | hilo_rd);

    assign w_div_zero = op[1] & (rt_val == '0);

`ifdef MULDIV_SIGNED_EN
    logic w_op_signed;
    logic w_rs_neg;
    logic w_rt_neg;
    logic r_neg_res;    // quotient / product must be negated
    logic r_neg_rem;    // remainder follows the dividend sign

    assign w_op_signed = ~op[0];
    assign w_rs_neg    = w_op_signed & rs_val[WIDTH-1];
    assign w_rt_neg    = w_op_signed & rt_val[WIDTH-1];
    assign w_rs_mag    = w_rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign w_rt_mag    = w_rt_neg ? (~rt_val + 1'b1) : rt_val;

    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                              : r_acc[2*WIDTH-1:WIDTH];

    // Sign information captured alongside the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (enable && (r_state == ST_IDLE) && start) begin
            r_neg_res <= w_rs_neg ^ w_rt_neg;
            r_neg_rem <= w_rs_neg;
        end
    end
`else
    logic w_unused_op0;

    // Unsigned-only build: the signedness bit has no effect.
    assign w_unused_op0 = op[0];
    assign w_rs_mag     = rs_val;
    assign w_rt_mag     = rt_val;
    assign w_prod       = r_acc;
    assign w_quo        = r_acc[WIDTH-1:0];
    assign w_rem        = r_acc[2*WIDTH-1:WIDTH];
`endif

    // One shift-add multiply step: add multiplicand when the LSB is set,
    // then shift the (WIDTH+1)-bit sum and the multiplier right together.
    always_comb begin
        w_mul_addend = r_acc[0] ? {1'b0, r_opnd} : '0;
        w_mul_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_mul_addend;
        w_mul_next   = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    // One restoring divide step: shift in the next dividend bit, keep the
    // trial difference only when it stays non-negative.
    always_comb begin
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_trial = w_div_shift - {1'b0, r_opnd};
        if (w_div_trial[WIDTH]) begin
            w_div_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a disabled edge holds the current state
    always_comb begin
        w_state_nxt = r_state;
        if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = w_div_zero ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_count == c_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Operand capture, iteration and HI/LO write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_is_div    <= 1'b0;
            r_dbz       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count  <= '0;
                        r_is_div <= op[1];
                        r_dbz    <= w_div_zero;
                        if (w_div_zero) begin
                            r_acc <= {rs_val, {WIDTH{1'b1}}};
                        end else if (op[1]) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_rs_mag};
                            r_opnd <= w_rt_mag;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_rt_mag};
                            r_opnd <= w_rs_mag;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc   <= r_is_div ? w_div_next : w_mul_next;
                    r_count <= r_count + 1'b1;
                end
                ST_DONE: begin
                    if (r_dbz) begin
                        hi <= r_acc[2*WIDTH-1:WIDTH];
                        lo <= r_acc[WIDTH-1:0];
                    end else if (r_is_div) begin
                        hi <= w_rem;
                        lo <= w_quo;
                    end else begin
                        hi <= w_prod[2*WIDTH-1:WIDTH];
                        lo <= w_prod[WIDTH-1:0];
                    end
                    done        <= 1'b1;
                    div_by_zero <= r_dbz;
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the 5-stage MIPS pipeline's EX stage. It executes mult/multu/div/divu (funct 011000–011011) over WIDTH cycles using one shift-add or restore-subtract step per cycle, and owns the HI/LO registers. It also raises a pipeline stall while an operation is in flight and a later instruction needs the unit or HI/LO.

## Interface
Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global pipeline enable; low freezes all state.
- start  in  1  EX stage holds a mult/div instruction.
- op  in  2  funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu.
- rs_val  in  WIDTH  dividend / multiplicand.
- rt_val  in  WIDTH  divisor / multiplier.
- hilo_rd  in  1  ID stage holds mfhi/mflo.
- stall  out  1  hold IF/ID/EX; combinational.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  valid with done; set when div/divu had rt_val==0.
- hi  out  WIDTH  HI register (product high half / remainder).
- lo  out  WIDTH  LO register (product low half / quotient).

## Operation
- FSM states:
  - IDLE: accepts start.
  - CALC: iterates.
  - DONE: finalises and writes HI/LO.
- `busy = (state != IDLE)`.
- `stall = busy & (start | hilo_rd)`. A start presented while busy is ignored; the stall holds it until it is re-presented.
- IDLE + start + enable:
  - Capture the operands (magnitudes for signed ops) and the sign info.
  - Clear the counter and go to CALC.
  - Exception: div/divu with rt_val==0 goes straight to DONE with the dbz flag latched.
- CALC: one step per enabled edge.
  - Multiply: add-and-shift on a 2×WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bit = 1 when the trial remainder is non-negative.
  - The counter runs 0..WIDTH-1. The edge at which count==WIDTH-1 performs the last step and moves to DONE.
- DONE edge:
  - Apply sign correction.
  - Write hi/lo and set done=1 for exactly one cycle.
  - Drive div_by_zero from the latched flag.
  - Go to IDLE.
- Signed correction:
  - Product is negated when operand signs differ.
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
- Divide by zero: hi=rs_val (raw), lo={WIDTH{1'b1}}, div_by_zero=1.
- All arithmetic is modulo 2×WIDTH for products and WIDTH for the quotient/remainder. Counter width is clog2(WIDTH).
- enable low: state, counter, accumulator, hi, lo and done hold their values. A pending done pulse stays high until the next enabled edge.
- rst (any state, including mid-operation):
  - state=IDLE, counter=0.
  - hi=0, lo=0, done=0, div_by_zero=0, busy=0.
  - The in-flight result is discarded.

## Timing
- Start sampled at edge E0, all edges enabled:
  - busy high from E0 to E(WIDTH+1).
  - DONE entered at E(WIDTH).
  - hi/lo updated and done=1 after E(WIDTH+1); busy=0 in the same cycle.
  - Latency for WIDTH=32: 33 edges.
- Divide by zero: DONE at E0; result and done after E1.
- Back-to-back: start in the done cycle is accepted at that edge, with no bubble.
- Each disabled edge adds exactly one cycle to latency.
- hi/lo change only on a DONE edge or on rst.
- stall is combinational from registered busy and the inputs.

## Configuration
- MULDIV_SIGNED_EN defined:
  - op 00 and 10 use signed (two's-complement) semantics.
  - op 01 and 11 are unsigned.
- Undefined:
  - op[0] is ignored and all four ops execute unsigned.
  - The sign-capture and correction logic is removed.
  - Divide-by-zero and timing behaviour are unchanged.

## Test plan
- mult rs=4, rt=2 at E0:
  - busy for 33 cycles, then done pulse exactly 1 cycle.
  - hi=0x00000000, lo=0x00000008.
- multu 0xFFFFFFFF × 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- Signed ops:
  - With the macro: mult 0xFFFFFFFF × 0xFFFFFFFF gives hi=0, lo=1.
  - With the macro: div 7 / 0xFFFFFFFE gives lo=0xFFFFFFFD, hi=0x00000001.
  - Without the macro: the same div gives lo=0, hi=7.
- div 5 / 0: done one edge after capture, hi=5, lo=0xFFFFFFFF, div_by_zero=1; next div 9/3 gives div_by_zero=0, lo=3, hi=0.
- Stall and reset:
  - hilo_rd=1 and a second start during busy: stall=1 every busy cycle, 0 in the done cycle, and the second op is accepted there.
  - rst pulsed at iteration 10 of a mult: busy=0, hi=lo=0, no done pulse.
- enable low for 5 cycles mid-CALC: state and counter frozen; done arrives exactly 5 cycles later than nominal with correct hi/lo.
